// File: rtl/exit_mon_pkg.sv
// exit_mon_pkg
//   Shared definitions for the retire exit monitor: status encodings,
//   FSM state codes, default parameter values and a small status helper.
package exit_mon_pkg;

  // Status codes reported on the status output
  localparam logic [1:0] ST_RUN  = 2'b00;
  localparam logic [1:0] ST_PASS = 2'b01;
  localparam logic [1:0] ST_FAIL = 2'b10;
  localparam logic [1:0] ST_HANG = 2'b11;

  // Monitor FSM state codes
  localparam logic [1:0] RUN   = 2'b00;
  localparam logic [1:0] DRAIN = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  // Default parameter values
  localparam int DEF_XLEN         = 32;
  localparam int DEF_CNT_W        = 64;
  localparam int DEF_STALL_LIMIT  = 100000;
  localparam int DEF_MAX_CYCLES   = 0;
  localparam int DEF_DRAIN_CYCLES = 10;

  // Status for an ebreak halt: a0 == 0 means the program passed
  function automatic logic [1:0] break_status(input logic a0_is_zero);
    if (a0_is_zero) begin
      return ST_PASS;
    end else begin
      return ST_FAIL;
    end
  endfunction

endpackage

// File: rtl/retire_exit_monitor_sat_counter.sv
// sat_counter
//   Width-parameterised up counter that sticks at all-ones.
//   Ports:
//     clock    : clock
//     clr_i    : synchronous clear (wins over enable)
//     en_i     : count enable
//     count_o  : current count (registered)
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  // Count register: clear, else increment unless already saturated
  always_ff @(posedge clock) begin
    if (clr_i) begin
      count_q <= {W{1'b0}};
    end else if (en_i && (count_q != {W{1'b1}})) begin
      count_q <= count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_q <= count_q;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/retire_exit_monitor.sv
// retire_exit_monitor
//   End-of-run monitor on the retire stream. Detects an ebreak (pass/fail),
//   a retire stall (hang) or a global cycle budget overrun (timeout), drains
//   for DRAIN_CYCLES, then raises a sticky done.
//   Ports:
//     clock, reset           : clock and synchronous active-high reset
//     retire_valid           : an instruction retires this cycle
//     retire_is_break        : retiring instruction is ebreak
//     retire_a0, retire_pc   : x10 and pc of the retiring instruction
//     halted, done           : sticky halt / drain-complete flags
//     status                 : 00 run, 01 pass, 10 fail, 11 hang/timeout
//     exit_code, halt_pc     : captured a0 and pc at the halt event
//     cycle_cnt, instret_cnt : cycles and retires counted while in RUN
module retire_exit_monitor
  import exit_mon_pkg::*;
#(
  parameter int XLEN         = DEF_XLEN,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int STALL_LIMIT  = DEF_STALL_LIMIT,
  parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             retire_valid,
  input  logic             retire_is_break,
  input  logic [XLEN-1:0]  retire_a0,
  input  logic [XLEN-1:0]  retire_pc,
  output logic             halted,
  output logic             done,
  output logic [1:0]       status,
  output logic [XLEN-1:0]  exit_code,
  output logic [XLEN-1:0]  halt_pc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  // Stall counter only needs to reach STALL_LIMIT-1; drain counter DRAIN_CYCLES-1
  localparam int STALL_W = $clog2(STALL_LIMIT);
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST =
    DRAIN_W'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0]   MAX_LAST =
    CNT_W'((MAX_CYCLES > 0) ? (MAX_CYCLES - 1) : 0);

  logic [1:0]         state_q, state_d;
  logic               halted_q, halted_d;
  logic               done_q, done_d;
  logic [1:0]         status_q, status_d;
  logic [XLEN-1:0]    exit_code_q, exit_code_d;
  logic [XLEN-1:0]    halt_pc_q, halt_pc_d;
  logic [XLEN-1:0]    last_pc_q, last_pc_d;

  logic [CNT_W-1:0]   cycle_q, instret_q;
  logic [STALL_W-1:0] stall_q;
  logic [DRAIN_W-1:0] drain_q;

  logic in_run, in_drain;
  logic brk_ev, hang_ev, tmo_ev;

  assign in_run   = (state_q == RUN);
  assign in_drain = (state_q == DRAIN);

  assign brk_ev  = retire_valid & retire_is_break;
  assign hang_ev = ~retire_valid & (stall_q == STALL_LAST);
  assign tmo_ev  = (MAX_CYCLES != 0) && (cycle_q == MAX_LAST);

  sat_counter #(.W(CNT_W)) u_cycle (
    .clock   (clock),
    .clr_i   (reset),
    .en_i    (in_run),
    .count_o (cycle_q)
  );

  sat_counter #(.W(CNT_W)) u_instret (
    .clock   (clock),
    .clr_i   (reset),
    .en_i    (in_run & retire_valid),
    .count_o (instret_q)
  );

  // Any retire restarts the stall window
  sat_counter #(.W(STALL_W)) u_stall (
    .clock   (clock),
    .clr_i   (reset | (in_run & retire_valid)),
    .en_i    (in_run & ~retire_valid),
    .count_o (stall_q)
  );

  // Held at zero outside DRAIN so each drain period starts fresh
  sat_counter #(.W(DRAIN_W)) u_drain (
    .clock   (clock),
    .clr_i   (reset | ~in_drain),
    .en_i    (in_drain),
    .count_o (drain_q)
  );

  // Next-state logic: halt event capture in RUN, drain countdown in DRAIN
  always_comb begin
    state_d     = state_q;
    halted_d    = halted_q;
    done_d      = done_q;
    status_d    = status_q;
    exit_code_d = exit_code_q;
    halt_pc_d   = halt_pc_q;
    last_pc_d   = last_pc_q;
    case (state_q)
      RUN: begin
        if (retire_valid) begin
          last_pc_d = retire_pc;
        end else begin
          last_pc_d = last_pc_q;
        end
        if (brk_ev || hang_ev || tmo_ev) begin
          halted_d = 1'b1;
          if (DRAIN_CYCLES == 0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
            done_d  = 1'b0;
          end
          if (brk_ev) begin
            status_d    = break_status(retire_a0 == {XLEN{1'b0}});
            exit_code_d = retire_a0;
            halt_pc_d   = retire_pc;
          end else begin
            // Hang and timeout report the most recent retire, including this cycle's
            status_d    = ST_HANG;
            exit_code_d = {XLEN{1'b0}};
            halt_pc_d   = retire_valid ? retire_pc : last_pc_q;
          end
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State and captured-output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RUN;
      halted_q    <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= ST_RUN;
      exit_code_q <= {XLEN{1'b0}};
      halt_pc_q   <= {XLEN{1'b0}};
      last_pc_q   <= {XLEN{1'b0}};
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      done_q      <= done_d;
      status_q    <= status_d;
      exit_code_q <= exit_code_d;
      halt_pc_q   <= halt_pc_d;
      last_pc_q   <= last_pc_d;
    end
  end

  assign halted      = halted_q;
  assign done        = done_q;
  assign status      = status_q;
  assign exit_code   = exit_code_q;
  assign halt_pc     = halt_pc_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: tb/tb_retire_exit_monitor.sv
// tb_retire_exit_monitor
//   Directed bench. Instance a: STALL_LIMIT=8, MAX_CYCLES=16, DRAIN_CYCLES=10.
//   Instance b: STALL_LIMIT=8, MAX_CYCLES=0, DRAIN_CYCLES=0. Both share inputs.
module tb_retire_exit_monitor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        retire_valid = 1'b0;
  logic        retire_is_break = 1'b0;
  logic [31:0] retire_a0 = 32'd0;
  logic [31:0] retire_pc = 32'd0;

  logic        a_halted, a_done, b_halted, b_done;
  logic [1:0]  a_status, b_status;
  logic [31:0] a_exit, a_hpc, b_exit, b_hpc;
  logic [63:0] a_cyc, a_ins, b_cyc, b_ins;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  retire_exit_monitor #(
    .XLEN(32), .CNT_W(64), .STALL_LIMIT(8), .MAX_CYCLES(16), .DRAIN_CYCLES(10)
  ) u_a (
    .clock(clock), .reset(reset), .retire_valid(retire_valid),
    .retire_is_break(retire_is_break), .retire_a0(retire_a0), .retire_pc(retire_pc),
    .halted(a_halted), .done(a_done), .status(a_status), .exit_code(a_exit),
    .halt_pc(a_hpc), .cycle_cnt(a_cyc), .instret_cnt(a_ins)
  );

  retire_exit_monitor #(
    .XLEN(32), .CNT_W(64), .STALL_LIMIT(8), .MAX_CYCLES(0), .DRAIN_CYCLES(0)
  ) u_b (
    .clock(clock), .reset(reset), .retire_valid(retire_valid),
    .retire_is_break(retire_is_break), .retire_a0(retire_a0), .retire_pc(retire_pc),
    .halted(b_halted), .done(b_done), .status(b_status), .exit_code(b_exit),
    .halt_pc(b_hpc), .cycle_cnt(b_cyc), .instret_cnt(b_ins)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then sample 1 time unit later
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic b, input logic [31:0] a0, input logic [31:0] pc);
    retire_valid    = v;
    retire_is_break = b;
    retire_a0       = a0;
    retire_pc       = pc;
  endtask

  initial begin
    // ---- Reset state ----
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("rst_halted", {63'd0, a_halted}, 64'd0);
    chk("rst_done", {63'd0, a_done}, 64'd0);
    chk("rst_status", {62'd0, a_status}, 64'd0);
    chk("rst_exit", {32'd0, a_exit}, 64'd0);
    chk("rst_hpc", {32'd0, a_hpc}, 64'd0);
    chk("rst_cyc", a_cyc, 64'd0);
    chk("rst_ins", a_ins, 64'd0);

    // ---- Pass: 5 retires then ebreak with a0 = 0 ----
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'd5, 32'h100 + 32'(4 * i));
      tick();
    end
    chk("pass_pre_halted", {63'd0, a_halted}, 64'd0);
    chk("pass_pre_ins", a_ins, 64'd5);
    chk("d0_pre_done", {63'd0, b_done}, 64'd0);
    drive(1'b1, 1'b1, 32'd0, 32'h114);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    chk("pass_halted", {63'd0, a_halted}, 64'd1);
    chk("pass_status", {62'd0, a_status}, 64'd1);
    chk("pass_exit", {32'd0, a_exit}, 64'd0);
    chk("pass_hpc", {32'd0, a_hpc}, 64'h114);
    chk("pass_ins", a_ins, 64'd6);
    chk("pass_cyc", a_cyc, 64'd6);
    chk("pass_done_early", {63'd0, a_done}, 64'd0);
    // DRAIN_CYCLES = 0 instance: halted and done on the same edge
    chk("d0_halted", {63'd0, b_halted}, 64'd1);
    chk("d0_done", {63'd0, b_done}, 64'd1);
    chk("d0_status", {62'd0, b_status}, 64'd1);
    for (int i = 0; i < 9; i++) tick();
    chk("pass_done_9", {63'd0, a_done}, 64'd0);
    tick();
    chk("pass_done_10", {63'd0, a_done}, 64'd1);
    chk("pass_cyc_frozen", a_cyc, 64'd6);

    // ---- Fail: ebreak with a0 = 3, then a second ebreak in DRAIN ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'd1, 32'h200);
    tick();
    drive(1'b1, 1'b1, 32'd3, 32'h204);
    tick();
    chk("fail_status", {62'd0, a_status}, 64'd2);
    chk("fail_exit", {32'd0, a_exit}, 64'd3);
    chk("fail_hpc", {32'd0, a_hpc}, 64'h204);
    chk("fail_ins", a_ins, 64'd2);
    drive(1'b1, 1'b1, 32'd0, 32'h300);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    chk("fail2_status", {62'd0, a_status}, 64'd2);
    chk("fail2_exit", {32'd0, a_exit}, 64'd3);
    chk("fail2_hpc", {32'd0, a_hpc}, 64'h204);
    chk("fail2_ins", a_ins, 64'd2);
    chk("fail2_cyc", a_cyc, 64'd2);

    // ---- Reset during DRAIN, then a fresh passing run ----
    reset = 1'b1;
    tick();
    chk("mrst_halted", {63'd0, a_halted}, 64'd0);
    chk("mrst_done", {63'd0, a_done}, 64'd0);
    chk("mrst_status", {62'd0, a_status}, 64'd0);
    chk("mrst_cyc", a_cyc, 64'd0);
    chk("mrst_ins", a_ins, 64'd0);
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'd7, 32'h500);
    tick();
    drive(1'b1, 1'b1, 32'd0, 32'h504);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    chk("rerun_status", {62'd0, a_status}, 64'd1);
    chk("rerun_hpc", {32'd0, a_hpc}, 64'h504);
    chk("rerun_ins", a_ins, 64'd2);
    for (int i = 0; i < 10; i++) tick();
    chk("rerun_done", {63'd0, a_done}, 64'd1);

    // ---- Hang: one retire, then silence; halt 8 edges after the retire ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'd9, 32'h8000_0010);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 7; i++) tick();
    chk("hang_pre_halted", {63'd0, a_halted}, 64'd0);
    tick();
    chk("hang_halted", {63'd0, a_halted}, 64'd1);
    chk("hang_status", {62'd0, a_status}, 64'd3);
    chk("hang_exit", {32'd0, a_exit}, 64'd0);
    chk("hang_hpc", {32'd0, a_hpc}, 64'h8000_0010);
    chk("hang_cyc", a_cyc, 64'd9);
    chk("hang_ins", a_ins, 64'd1);

    // ---- ebreak on the same cycle as the cycle budget expires ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 1'b0, 32'd1, 32'h400 + 32'(4 * i));
      tick();
    end
    chk("sim_pre_halted", {63'd0, a_halted}, 64'd0);
    chk("sim_pre_cyc", a_cyc, 64'd15);
    drive(1'b1, 1'b1, 32'd0, 32'h43C);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    chk("sim_status", {62'd0, a_status}, 64'd1);
    chk("sim_cyc", a_cyc, 64'd16);
    chk("sim_ins", a_ins, 64'd16);
    chk("sim_hpc", {32'd0, a_hpc}, 64'h43C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/retire_exit_monitor.md
Name: retire_exit_monitor

Overview:
Synthesizable end-of-run monitor attached to the core's memory/retire stage. It consumes the per-cycle retire stream (valid, ebreak flag, a0 value, pc) and decides pass, fail or hang. It drains for a fixed number of cycles, then raises a sticky done with a status code, exit code and performance counters. Simulation benches and FPGA top-levels key their finish and report logic off this block, not off internal pipeline signals.

Parameters:
XLEN, 32, width of a0 and pc
CNT_W, 64, width of the cycle and instret counters
STALL_LIMIT, 100000, consecutive non-retire cycles in RUN that declare a hang; must be >= 2
MAX_CYCLES, 0, global cycle budget; 0 disables the check
DRAIN_CYCLES, 10, cycles between the halt event and done; 0 is legal

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high
retire_valid  in  1  one instruction retires this cycle (the memory stage's valid)
retire_is_break  in  1  the retiring instruction is ebreak; qualified by retire_valid
retire_a0  in  XLEN  architectural x10 value as seen by the retiring instruction
retire_pc  in  XLEN  pc of the retiring instruction
halted  out  1  halt event captured; sticky
done  out  1  drain finished; sticky
status  out  2  00 running, 01 pass, 10 fail, 11 hang/timeout
exit_code  out  XLEN  a0 captured at the halt event
halt_pc  out  XLEN  pc at the halt event, or pc of the last retire for a hang/timeout
cycle_cnt  out  CNT_W  cycles spent in RUN
instret_cnt  out  CNT_W  instructions retired in RUN, including the ebreak

Behaviour:
- Interface: one clock, `clock`. `reset` is synchronous and active-high; all state updates on the rising edge.
- Reset sets every output to 0, the state to RUN and the stall counter to 0.
- Reset asserted mid-run, including during DRAIN or DONE, returns the block to RUN with all counters cleared on the next edge.
- States:
  - RUN: collects retire events; cycle_cnt increments every cycle.
  - DRAIN: counters frozen; the drain counter counts up.
  - DONE: everything frozen; only reset leaves this state.
- In RUN, each cycle with retire_valid increments instret_cnt, records retire_pc as last_pc and clears the stall counter.
- In RUN, each cycle without retire_valid increments the stall counter.
- Counters saturate at all-ones and never wrap.
- Halt event priority within a cycle, highest first:
  1. retire_valid & retire_is_break: status = 01 if retire_a0 == 0, else 10. exit_code = retire_a0, halt_pc = retire_pc.
  2. Stall counter reaches STALL_LIMIT-1 with no retire this cycle: status = 11, exit_code = 0, halt_pc = last_pc.
  3. MAX_CYCLES != 0 and cycle_cnt reaches MAX_CYCLES-1: status = 11, exit_code = 0, halt_pc = last_pc.
- Effects visible on the edge that captures the halt event:
  - halted = 1 and status, exit_code and halt_pc are set.
  - The ebreak itself is counted in instret_cnt and that cycle is counted in cycle_cnt.
- Transition after the halt event:
  - DRAIN_CYCLES = 0: go straight to DONE; done rises on the same edge as halted.
  - Otherwise: go to DRAIN; done rises exactly DRAIN_CYCLES edges after halted.
- Retire inputs are ignored in DRAIN and DONE; a second ebreak never changes the captured outputs.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package (exit_mon_pkg):
  - status encodings: ST_RUN, ST_PASS, ST_FAIL, ST_HANG
  - FSM state enum: RUN, DRAIN, DONE
  - default parameter constants
- One natural sub-module: sat_counter. Width-parameterised saturating counter with clear and enable inputs. Instantiated for cycle_cnt, instret_cnt, the stall counter and the drain counter.

Test Plan:
- Pass: reset 20 cycles, 5 retires, then ebreak retire with a0 = 0 -> halted next edge, status = 01, exit_code = 0, instret_cnt = 6; done exactly 10 cycles later.
- Fail: ebreak retire with a0 = 0x0000_0003 -> status = 10, exit_code = 3, halt_pc equals that retire's pc; a further ebreak in DRAIN leaves all outputs unchanged.
- Hang: STALL_LIMIT = 8, one retire at pc 0x8000_0010, then no retires -> status = 11 exactly 8 cycles after the last retire, halt_pc = 0x8000_0010.
- Simultaneous events: ebreak with a0 = 0 on the same cycle cycle_cnt hits MAX_CYCLES-1 = 15 -> status = 01, not 11; cycle_cnt = 16.
- Reset mid-run: assert reset during DRAIN -> next edge halted = done = 0, status = 00, counters = 0; a new run then passes normally.
- DRAIN_CYCLES = 0: ebreak with a0 = 0 -> halted and done rise on the same edge.
